// File: rtl/adc_spi_pkg.sv
// Shared constants and FSM encoding for the serial ADC reader.
// Used by adc_spi_reader and sclk_tick_gen.
package adc_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BIT0  = 2;
  localparam int DATA_BIT0  = 4;
  localparam int AVG_N      = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  // Address bit driven on DIN for frame bit k (MSB first).
  function automatic logic addr_bit(
    input logic [2:0] ch,
    input logic [3:0] k
  );
    logic b;
    b = 1'b0;
    if (k == 4'(ADDR_BIT0))
      b = ch[2];
    else if (k == 4'(ADDR_BIT0 + 1))
      b = ch[1];
    else if (k == 4'(ADDR_BIT0 + 2))
      b = ch[0];
    return b;
  endfunction

endpackage

// File: rtl/adc_spi_reader_sclk.sv
// Serial clock divider: CLK_DIV clks per half period, idles high.
// Restarts at zero whenever i_en rises; first tick is a falling edge.
module sclk_tick_gen
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_fall,
  output logic o_rise,
  output logic o_sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_fall = w_wrap && r_sclk;
  assign o_rise = w_wrap && !r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for an 8-channel 12-bit serial ADC, one sample per frame.
// Define ADC_AVG_EN for a 4-frame per-channel boxcar average.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 12
) (
  input  logic              clk,
  input  logic              spi_rst,
  input  logic              spi_go,
  input  logic [2:0]        adc_ch,
  input  logic              idout,
  output logic              odin,
  output logic              ocs_n,
  output logic              osclk,
  output logic [DATA_W-1:0] sample,
  output logic [2:0]        sample_ch,
  output logic              sample_valid,
  output logic              busy
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t            r_state;
  logic [CW-1:0]     r_div;
  logic [3:0]        r_bit;
  logic [2:0]        r_ch_cur;
  logic [2:0]        r_ch_prev;
  logic [2:0]        r_sample_ch;
  logic [DATA_W-2:0] r_shift;
  logic [DATA_W-1:0] r_sample;
  logic              r_odin;
  logic              r_ocs_n;
  logic              r_valid;
  logic              r_busy;
  logic              r_primed;

  logic              w_en;
  logic              w_fall;
  logic              w_rise;
  logic              w_sclk;
  logic              w_div_end;
  logic              w_last;
  logic [DATA_W-1:0] w_raw;

  assign w_en      = (r_state == S_SHIFT);
  assign w_div_end = (r_div == CW'(CLK_DIV - 1));
  assign w_last    = w_rise && (r_bit == 4'(FRAME_BITS - 1));
  assign w_raw     = {r_shift, idout};

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (spi_rst),
    .i_en  (w_en),
    .o_fall(w_fall),
    .o_rise(w_rise),
    .o_sclk(w_sclk)
  );

`ifdef ADC_AVG_EN
  logic [DATA_W+1:0] r_acc;
  logic [DATA_W+1:0] w_sum;
  logic [2:0]        r_avg_n;
  logic [2:0]        r_avg_ch;
  logic [2:0]        w_n;
  logic              w_same;

  // A channel change restarts the sum instead of mixing channels.
  assign w_same = (r_avg_n != 3'd0) && (r_avg_ch == r_ch_prev);
  assign w_sum  = (w_same ? r_acc : '0) + {2'b00, w_raw};
  assign w_n    = (w_same ? r_avg_n : 3'd0) + 3'd1;
`endif

  always_ff @(posedge clk or negedge spi_rst) begin
    if (!spi_rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_ch_cur    <= '0;
      r_ch_prev   <= '0;
      r_sample_ch <= '0;
      r_shift     <= '0;
      r_sample    <= '0;
      r_odin      <= 1'b0;
      r_ocs_n     <= 1'b1;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_primed    <= 1'b0;
`ifdef ADC_AVG_EN
      r_acc       <= '0;
      r_avg_n     <= '0;
      r_avg_ch    <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (spi_go) begin
            r_state  <= S_SETUP;
            r_ch_cur <= adc_ch;
            r_ocs_n  <= 1'b0;
            r_busy   <= 1'b1;
            r_div    <= '0;
          end
        end
        S_SETUP: begin
          r_div <= r_div + 1'b1;
          if (w_div_end) begin
            r_state <= S_SHIFT;
            r_div   <= '0;
            r_bit   <= '0;
          end
        end
        S_SHIFT: begin
          if (w_fall)
            r_odin <= addr_bit(r_ch_cur, r_bit);
          if (w_rise) begin
            r_bit <= r_bit + 1'b1;
            if (r_bit >= 4'(DATA_BIT0))
              r_shift <= w_raw[DATA_W-2:0];
          end
          if (w_last) begin
            r_state   <= S_HOLD;
            r_div     <= '0;
            r_ocs_n   <= 1'b1;
            r_odin    <= 1'b0;
            r_primed  <= 1'b1;
            r_ch_prev <= r_ch_cur;
            // Data in this frame belongs to last frame's address.
            if (r_primed) begin
`ifdef ADC_AVG_EN
              if (w_n == 3'(AVG_N)) begin
                r_sample    <= w_sum[DATA_W+1:2];
                r_sample_ch <= r_ch_prev;
                r_valid     <= 1'b1;
                r_acc       <= '0;
                r_avg_n     <= '0;
              end else begin
                r_acc    <= w_sum;
                r_avg_n  <= w_n;
                r_avg_ch <= r_ch_prev;
              end
`else
              r_sample    <= w_raw;
              r_sample_ch <= r_ch_prev;
              r_valid     <= 1'b1;
`endif
            end
          end
        end
        S_HOLD: begin
          r_div <= r_div + 1'b1;
          if (w_div_end) begin
            r_div <= '0;
            if (spi_go) begin
              r_state  <= S_SETUP;
              r_ch_cur <= adc_ch;
              r_ocs_n  <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_primed <= 1'b0;
`ifdef ADC_AVG_EN
              r_acc    <= '0;
              r_avg_n  <= '0;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign odin         = r_odin;
  assign ocs_n        = r_ocs_n;
  assign osclk        = w_sclk;
  assign sample       = r_sample;
  assign sample_ch    = r_sample_ch;
  assign sample_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader with a behavioural serial ADC.
// Build with ADC_AVG_EN defined to exercise the averaging path.
module tb_adc_spi_reader;

  localparam int CD = 4;
  localparam int FR = 34 * CD;

  logic        clk     = 1'b0;
  logic        spi_rst = 1'b0;
  logic        spi_go  = 1'b0;
  logic [2:0]  adc_ch  = 3'd0;
  logic        idout   = 1'b0;
  logic        odin;
  logic        ocs_n;
  logic        osclk;
  logic [11:0] sample;
  logic [2:0]  sample_ch;
  logic        sample_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_spi_reader #(
    .CLK_DIV(CD),
    .DATA_W (12)
  ) dut (
    .clk         (clk),
    .spi_rst     (spi_rst),
    .spi_go      (spi_go),
    .adc_ch      (adc_ch),
    .idout       (idout),
    .odin        (odin),
    .ocs_n       (ocs_n),
    .osclk       (osclk),
    .sample      (sample),
    .sample_ch   (sample_ch),
    .sample_valid(sample_valid),
    .busy        (busy)
  );

  // ADC model: returns the channel addressed in the previous frame
  int          fcnt      = 0;
  int          avg_idx   = 0;
  logic        avg_mode  = 1'b0;
  logic [2:0]  m_addr    = 3'd0;
  logic [2:0]  m_ch_data = 3'd0;
  logic [11:0] m_word    = 12'd0;
  logic [15:0] m_odin    = 16'd0;
  logic [15:0] last_odin = 16'd0;

  function automatic logic [11:0] adc_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return 12'hA5C;
      3'd5:    return 12'h3F1;
      3'd7:    return 12'hFFF;
      default: return {9'd0, ch};
    endcase
  endfunction

  function automatic logic [11:0] avg_word(input int i);
    case (i % 4)
      0:       return 12'd100;
      1:       return 12'd200;
      2:       return 12'd300;
      default: return 12'd404;
    endcase
  endfunction

  always @(negedge ocs_n) begin
    fcnt   = 0;
    m_odin = 16'd0;
    if (avg_mode && m_ch_data == 3'd5) begin
      m_word  = avg_word(avg_idx);
      avg_idx = avg_idx + 1;
    end else begin
      m_word = adc_val(m_ch_data);
    end
  end

  always @(negedge osclk) begin
    if (ocs_n === 1'b0 && fcnt < 16) begin
      idout = (fcnt >= 4) ? m_word[15 - fcnt] : 1'b0;
      fcnt  = fcnt + 1;
    end
  end

  always @(posedge osclk) begin
    if (fcnt >= 1 && fcnt <= 16) begin
      m_odin[fcnt - 1] = odin;
      if (fcnt >= 3 && fcnt <= 5)
        m_addr[5 - fcnt] = odin;
    end
  end

  always @(posedge ocs_n) begin
    last_odin = m_odin;
    if (fcnt == 16)
      m_ch_data = m_addr;
  end

  // Output monitors
  int          cyc    = 0;
  int          nval   = 0;
  int          nfr    = 0;
  int          vrun   = 0;
  int          maxrun = 0;
  int          lowcnt = 0;
  int          lastlow = 0;
  int          bad    = 0;
  int          vcyc   = 0;
  int          gap    = 0;
  int          vnfr   = 0;
  logic [11:0] vs     = 12'd0;
  logic [2:0]  vch    = 3'd0;

  always @(posedge clk) cyc = cyc + 1;
  always @(negedge ocs_n) nfr = nfr + 1;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      nval = nval + 1;
      vrun = vrun + 1;
      gap  = cyc - vcyc;
      vcyc = cyc;
      vs   = sample;
      vch  = sample_ch;
      vnfr = nfr;
    end else begin
      if (vrun > maxrun) maxrun = vrun;
      vrun = 0;
    end
    if (ocs_n === 1'b0) begin
      lowcnt = lowcnt + 1;
      if (lowcnt <= CD && osclk !== 1'b1) bad = bad + 1;
    end else begin
      if (lowcnt > 0) lastlow = lowcnt;
      lowcnt = 0;
      if (osclk !== 1'b1 || odin !== 1'b0) bad = bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_val(input int target, input int budget);
    for (int i = 0; i < budget && nval < target; i++) @(negedge clk);
  endtask

  task automatic wait_nfr(input string tag);
    int t;
    t = nfr + 1;
    for (int i = 0; i < 2 * FR && nfr < t; i++) @(negedge clk);
    chk(tag, 32'(nfr >= t), 32'd1);
  endtask

  task automatic wait_fcnt(input string tag, input int k);
    for (int i = 0; i < FR && fcnt < k; i++) @(negedge clk);
    chk(tag, 32'(fcnt >= k), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2 * FR && busy !== 1'b0; i++) @(negedge clk);
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int bfr;
    repeat (3) @(negedge clk);
    chk("rst_ocs_n", 32'(ocs_n), 32'd1);
    chk("rst_osclk", 32'(osclk), 32'd1);
    chk("rst_odin", 32'(odin), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_sample_ch", 32'(sample_ch), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    spi_rst = 1'b1;
    @(negedge clk);
`ifndef ADC_AVG_EN
    adc_ch = 3'd5;
    spi_go = 1'b1;
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (FR) @(negedge clk);
    chk("t1_prime_no_valid", 32'(nval), 32'd0);
    wait_val(1, FR);
    chk("t1_first_valid", 32'(nval), 32'd1);
    chk("t1_sample", 32'(vs), 32'h3F1);
    chk("t1_sample_ch", 32'(vch), 32'd5);
    wait_val(2, FR + 4);
    chk("t1_second_valid", 32'(nval), 32'd2);
    chk("t1_gap", 32'(gap), 32'(FR));
    chk("t1_pulse_width", 32'(maxrun), 32'd1);
    chk("t2_odin_bits", 32'(last_odin), 32'h0014);
    chk("t2_cs_low_len", 32'(lastlow), 32'(33 * CD));
    chk("t2_idle_levels", 32'(bad), 32'd0);

    wait_nfr("t3_frame_n");
    adc_ch = 3'd0;
    wait_nfr("t3_frame_n1");
    adc_ch = 3'd7;
    wait_nfr("t3_frame_n2");
    base = nval;
    wait_val(base + 1, FR + 4);
    chk("t3_cnt_a", 32'(nval), 32'(base + 1));
    chk("t3_sample_a", 32'(vs), 32'hA5C);
    chk("t3_ch_a", 32'(vch), 32'd0);
    wait_val(base + 2, FR + 4);
    chk("t3_cnt_b", 32'(nval), 32'(base + 2));
    chk("t3_sample_b", 32'(vs), 32'hFFF);
    chk("t3_ch_b", 32'(vch), 32'd7);

    wait_nfr("t4_frame");
    wait_fcnt("t4_k8", 9);
    spi_go = 1'b0;
    base = nval;
    wait_idle("t4_busy_low");
    chk("t4_one_valid", 32'(nval), 32'(base + 1));
    chk("t4_sample", 32'(vs), 32'hFFF);
    chk("t4_hold_len", 32'(cyc - vcyc), 32'(CD));
    repeat (2 * FR) @(negedge clk);
    chk("t4_quiet_valid", 32'(nval), 32'(base + 1));
    chk("t4_quiet_cs", 32'(ocs_n), 32'd1);
    adc_ch = 3'd5;
    spi_go = 1'b1;
    base = nval;
    repeat (FR + 1) @(negedge clk);
    chk("t4_reprime", 32'(nval), 32'(base));
    wait_val(base + 1, FR);
    chk("t4_after_prime", 32'(vs), 32'h3F1);
    chk("t4_after_prime_ch", 32'(vch), 32'd5);

    wait_nfr("t5_frame");
    wait_fcnt("t5_k10", 11);
    spi_rst = 1'b0;
    #1;
    chk("t5_ocs_n", 32'(ocs_n), 32'd1);
    chk("t5_osclk", 32'(osclk), 32'd1);
    chk("t5_odin", 32'(odin), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sample", 32'(sample), 32'd0);
    chk("t5_valid", 32'(sample_valid), 32'd0);
    base = nval;
    repeat (3) @(negedge clk);
    spi_rst = 1'b1;
    repeat (FR) @(negedge clk);
    chk("t5_no_valid", 32'(nval), 32'(base));
    spi_go = 1'b0;
    wait_idle("t5_idle");
    chk("t5_levels", 32'(bad), 32'd0);
`else
    avg_mode = 1'b1;
    adc_ch   = 3'd5;
    bfr      = nfr;
    base     = nval;
    spi_go   = 1'b1;
    wait_val(base + 1, 6 * FR);
    chk("t6_cnt", 32'(nval), 32'(base + 1));
    chk("t6_avg", 32'(vs), 32'd251);
    chk("t6_ch", 32'(vch), 32'd5);
    chk("t6_frame", 32'(vnfr - bfr), 32'd5);
    wait_nfr("t6_frame6");
    adc_ch = 3'd0;
    base = nval;
    wait_val(base + 1, 7 * FR);
    chk("t6_sw_cnt", 32'(nval), 32'(base + 1));
    chk("t6_sw_frame", 32'(vnfr - bfr), 32'd11);
    chk("t6_sw_avg", 32'(vs), 32'hA5C);
    chk("t6_sw_ch", 32'(vch), 32'd0);
    chk("t6_width", 32'(maxrun), 32'd1);
    spi_go = 1'b0;
    wait_idle("t6_idle");
    chk("t6_levels", 32'(bad), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
